// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared state encoding, RAM geometry defaults and rw levels
package ram_port_arbiter_pkg;
    localparam int W_DEF = 32;
    localparam int L_DEF = 16;
    localparam int AW_DEF = $clog2(L_DEF);
    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ = 1'b0;
    typedef enum logic [1:0] {ST_INIT, ST_ARB, ST_ACCESS} state_t;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester handshakes, shared read data and RAM pins
interface ram_port_arbiter_if
    import ram_port_arbiter_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int AW = AW_DEF
);
    logic a_req, a_we, a_gnt, a_rvalid;
    logic [AW-1:0] a_addr;
    logic [W-1:0] a_wdata;
    logic b_req, b_we, b_gnt, b_rvalid;
    logic [AW-1:0] b_addr;
    logic [W-1:0] b_wdata;
    logic [W-1:0] rdata;
    logic init_done;
    logic [AW-1:0] ram_addr;
    logic [W-1:0] ram_din, ram_dout;
    logic ram_rw, ram_oe;
    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_dout,
        input a_gnt, a_rvalid, b_gnt, b_rvalid, rdata, init_done, ram_addr, ram_din, ram_rw, ram_oe
    );
    modport slave (
        input a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_dout,
        output a_gnt, a_rvalid, b_gnt, b_rvalid, rdata, init_done, ram_addr, ram_din, ram_rw, ram_oe
    );
endinterface

// File: rtl/ram_port_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick with a registered last-winner bit
module rr_arbiter2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic take,
    output logic pick_b
);
    logic last_b;
    assign pick_b = req_b & (~req_a | ~last_b);
    // remember the winner whenever a grant is actually taken; reset favours A next
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) last_b <= 1'b1;
        else if (take) last_b <= pick_b;
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: clears the shared RAM, then serves A/B accesses round-robin
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int L = L_DEF,
    parameter int AW = $clog2(L)
) (
    input logic clk,
    input logic rst_n,
    ram_port_arbiter_if.slave bus
);
    state_t state, state_n;
    logic [AW-1:0] cnt, cnt_n, addr_q, addr_n;
    logic [W-1:0] din_q, din_n, rdata_q, rdata_n;
    logic rw_q, rw_n, oe_q, oe_n, done_q, done_n;
    logic ag_q, ag_n, bg_q, bg_n, av_q, av_n, bv_q, bv_n;
    logic any_req, take, pick_b;

    assign any_req = bus.a_req | bus.b_req;
    assign take = (state == ST_ARB) && any_req;

    rr_arbiter2 u_rr (
        .clk(clk),
        .rst_n(rst_n),
        .req_a(bus.a_req),
        .req_b(bus.b_req),
        .take(take),
        .pick_b(pick_b)
    );

    // next state and next registered outputs; the sweep's last word is still on the pins in the first ARB cycle
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        addr_n = addr_q;
        din_n = din_q;
        rw_n = RW_READ;
        oe_n = 1'b0;
        ag_n = 1'b0;
        bg_n = 1'b0;
        av_n = 1'b0;
        bv_n = 1'b0;
        rdata_n = rdata_q;
        done_n = done_q;
        case (state)
            ST_INIT: begin
                addr_n = cnt;
                din_n = '0;
                rw_n = RW_WRITE;
                cnt_n = cnt + AW'(1);
                state_n = (cnt == AW'(L - 1)) ? ST_ARB : ST_INIT;
            end
            ST_ARB: begin
                done_n = 1'b1;
                if (any_req) begin
                    addr_n = pick_b ? bus.b_addr : bus.a_addr;
                    din_n = pick_b ? bus.b_wdata : bus.a_wdata;
                    rw_n = pick_b ? bus.b_we : bus.a_we;
                    oe_n = ~rw_n;
                    ag_n = ~pick_b;
                    bg_n = pick_b;
                    state_n = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_n = ST_ARB;
                if (rw_q == RW_READ) begin
                    rdata_n = bus.ram_dout;
                    av_n = ag_q;
                    bv_n = bg_q;
                end
            end
            default: state_n = ST_INIT;
        endcase
    end

    // state and output registers; reset drops any in-flight access and restarts the sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
            cnt <= '0;
            addr_q <= '0;
            din_q <= '0;
            rw_q <= RW_READ;
            oe_q <= 1'b0;
            ag_q <= 1'b0;
            bg_q <= 1'b0;
            av_q <= 1'b0;
            bv_q <= 1'b0;
            rdata_q <= '0;
            done_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            addr_q <= addr_n;
            din_q <= din_n;
            rw_q <= rw_n;
            oe_q <= oe_n;
            ag_q <= ag_n;
            bg_q <= bg_n;
            av_q <= av_n;
            bv_q <= bv_n;
            rdata_q <= rdata_n;
            done_q <= done_n;
        end
    end

    assign bus.ram_addr = addr_q;
    assign bus.ram_din = din_q;
    assign bus.ram_rw = rw_q;
    assign bus.ram_oe = oe_q;
    assign bus.a_gnt = ag_q;
    assign bus.b_gnt = bg_q;
    assign bus.a_rvalid = av_q;
    assign bus.b_rvalid = bv_q;
    assign bus.rdata = rdata_q;
    assign bus.init_done = done_q;
endmodule
